// File: rtl/ec_walk_ctrl.sv
// Walk controller: feeds point P to an external P+G datapath, emits each result on valid/ready; result appears DP_LATENCY cycles
// after start/handshake, held stable under out_ready=0. Define EC_WALK_ABORT_EN to add an abort input that ends the walk early.
module ec_walk_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16,
    parameter int DP_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] seed_X,
    input  logic [DATA_WIDTH-1:0] seed_Y,
    input  logic [CNT_WIDTH-1:0]  steps,
    input  logic                  start,
`ifdef EC_WALK_ABORT_EN
    input  logic                  abort,
`endif
    output logic [DATA_WIDTH-1:0] dp_X_in,
    output logic [DATA_WIDTH-1:0] dp_Y_in,
    input  logic [DATA_WIDTH-1:0] dp_X_out,
    input  logic [DATA_WIDTH-1:0] dp_Y_out,
    output logic [DATA_WIDTH-1:0] out_X,
    output logic [DATA_WIDTH-1:0] out_Y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(DP_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    rem_q, rem_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0]   dpx_q, dpx_d, dpy_q, dpy_d;
    logic [DATA_WIDTH-1:0]   outx_q, outx_d, outy_q, outy_d;
    logic                    ov_q, ov_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        dpx_d   = dpx_q;
        dpy_d   = dpy_q;
        outx_d  = outx_q;
        outy_d  = outy_q;
        ov_d    = ov_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        rem_d   = steps;
                        dpx_d   = seed_X;
                        dpy_d   = seed_Y;
                        wcnt_d  = '0;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q + 4'd1;
                if (wcnt_q == WAIT_LAST) begin
                    outx_d  = dp_X_out;
                    outy_d  = dp_Y_out;
                    ov_d    = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    ov_d  = 1'b0;
                    rem_d = rem_q - CNT_WIDTH'(1);
                    if (rem_q == CNT_WIDTH'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // the point just emitted becomes the next operand
                        dpx_d   = outx_q;
                        dpy_d   = outy_q;
                        wcnt_d  = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef EC_WALK_ABORT_EN
        if (abort && (state_q == ST_WAIT || state_q == ST_EMIT)) begin
            ov_d    = 1'b0;
            state_d = ST_DONE;
            done_d  = 1'b1;
        end
`endif

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            wcnt_q  <= '0;
            dpx_q   <= '0;
            dpy_q   <= '0;
            outx_q  <= '0;
            outy_q  <= '0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            dpx_q   <= dpx_d;
            dpy_q   <= dpy_d;
            outx_q  <= outx_d;
            outy_q  <= outy_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign dp_X_in   = dpx_q;
    assign dp_Y_in   = dpy_q;
    assign out_X     = outx_q;
    assign out_Y     = outy_q;
    assign out_valid = ov_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ec_walk_ctrl.sv
// Bench for ec_walk_ctrl: behavioural P+G datapath on y^2=x^3+2x+2 mod 17, G=(5,1), two-cycle latency,
// plus a scoreboard that derives each walk's expected points and handshake timing.
module tb_ec_walk_ctrl;
    localparam int DW  = 64;
    localparam int CW  = 16;
    localparam int LAT = 2;

    typedef struct packed { int x; int y; } pt_t;
    localparam pt_t G = '{x: 5, y: 1};

    typedef struct {
        int sx, sy, nsteps, stall_at, stall_len;
        bit poke;
        int exp_n, exp_lx, exp_ly;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] seed_X, seed_Y, dp_X_in, dp_Y_in, dp_X_out, dp_Y_out, out_X, out_Y;
    logic [CW-1:0] steps;
    logic          start, out_valid, out_ready, busy, done;
`ifdef EC_WALK_ABORT_EN
    logic          abort;
`endif

    int  n_cmp = 0;
    int  n_bad = 0;
    pt_t got[$];
    pt_t dp_sum, dp_pipe;

    ec_walk_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .DP_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .seed_X(seed_X), .seed_Y(seed_Y), .steps(steps), .start(start),
`ifdef EC_WALK_ABORT_EN
        .abort(abort),
`endif
        .dp_X_in(dp_X_in), .dp_Y_in(dp_Y_in), .dp_X_out(dp_X_out), .dp_Y_out(dp_Y_out),
        .out_X(out_X), .out_Y(out_Y), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int m17(int a);
        return ((a % 17) + 17) % 17;
    endfunction

    function automatic int inv17(int a);
        for (int i = 1; i < 17; i++)
            if (m17(a * i) == 1) return i;
        return 0;
    endfunction

    function automatic pt_t ec_add(pt_t p, pt_t q);
        int  lam;
        pt_t r;
        if (p.x == q.x && p.y == q.y) lam = m17((3 * p.x * p.x + 2) * inv17(2 * p.y));
        else                          lam = m17((q.y - p.y) * inv17(q.x - p.x));
        r.x = m17(lam * lam - p.x - q.x);
        r.y = m17(lam * (p.x - r.x) - p.y);
        return r;
    endfunction

    // Datapath: one register stage after the adder gives the two-cycle operand-to-capture latency.
    always_comb dp_sum = ec_add('{x: m17(int'(dp_X_in[31:0])), y: m17(int'(dp_Y_in[31:0]))}, G);
    always @(posedge clk) dp_pipe <= dp_sum;
    assign dp_X_out = DW'(dp_pipe.x);
    assign dp_Y_out = DW'(dp_pipe.y);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_walk(input string tag, input pt_t seed, input int nsteps, input int stall_at,
                            input int stall_len, input bit rnd, input bit poke, input int abort_at);
        int            edges, nemit, stall_left, done_cnt, exp_n;
        bit            prev_v, hs, rdy, poked, finished;
        logic [DW-1:0] hx, hy, dpx0;
        pt_t           p;
        got.delete();
        nemit = 0; stall_left = stall_len; done_cnt = 0;
        prev_v = 0; hs = 0; poked = 0; finished = 0; hx = '0; hy = '0;
        @(posedge clk); #1;
        seed_X = DW'(seed.x); seed_Y = DW'(seed.y); steps = CW'(nsteps);
        start = 1'b1; out_ready = 1'b0;
        dpx0 = dp_X_in;
        @(posedge clk); #1;
        start = 1'b0;
        edges = -1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
`ifdef EC_WALK_ABORT_EN
            abort = 1'b0;
`endif
            edges = hs ? 0 : edges + 1;
            hs = 0;
            if (done_cnt > 0 && !done) begin
                check({tag, " busy_after"}, busy, 0);
                check({tag, " done_pulses"}, done_cnt, 1);
                finished = 1;
            end else begin
                if (done) begin
                    done_cnt++;
                    check({tag, " done_with_valid"}, out_valid, 0);
                end
                if (out_valid && !prev_v) begin
                    check({tag, " latency"}, edges, LAT);
                    hx = out_X; hy = out_Y;
                end else if (out_valid) begin
                    check({tag, " hold_x"}, out_X, hx);
                    check({tag, " hold_y"}, out_Y, hy);
                end
                if (poke && !poked && nemit == 0 && !out_valid && !done) begin
                    seed_X = 3; seed_Y = 7; steps = 9; start = 1'b1; poked = 1;
                end
                rdy = 0;
                if (out_valid) begin
                    if (abort_at == nemit) begin
`ifdef EC_WALK_ABORT_EN
                        abort = 1'b1;
`endif
                    end else if (rnd) rdy = 1'($urandom_range(0, 1));
                    else if (nemit == stall_at && stall_left > 0) stall_left--;
                    else rdy = 1;
                end
                out_ready = rdy;
                if (rdy) begin
                    got.push_back('{x: int'(out_X), y: int'(out_Y)});
                    nemit++;
                    hs = 1;
                end
                prev_v = out_valid && !rdy;
            end
        end
        out_ready = 1'b0;
        check({tag, " finished"}, finished, 1);
        exp_n = (abort_at >= 0 && abort_at < nsteps) ? abort_at : nsteps;
        check({tag, " count"}, got.size(), exp_n);
        p = seed;
        for (int i = 0; i < exp_n && i < got.size(); i++) begin
            p = ec_add(p, G);
            check({tag, " pt_x"}, got[i].x, p.x);
            check({tag, " pt_y"}, got[i].y, p.y);
        end
        if (nsteps == 0) check({tag, " dp_unchanged"}, dp_X_in, dpx0);
    endtask

    vec_t vecs[4];
    pt_t  rp;

    initial begin
        vecs[0] = '{5, 1, 4, -1, 0, 1'b0, 4, 9, 16};
        vecs[1] = '{5, 1, 3, 1, 5, 1'b0, 3, 3, 1};
        vecs[2] = '{5, 1, 0, -1, 0, 1'b0, 0, 0, 0};
        vecs[3] = '{5, 1, 2, -1, 0, 1'b1, 2, 10, 6};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        seed_X = '0; seed_Y = '0; steps = '0;
`ifdef EC_WALK_ABORT_EN
        abort = 1'b0;
`endif
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_out_x", out_X, 0);
        check("rst_out_y", out_Y, 0);
        check("rst_dp_x", dp_X_in, 0);
        check("rst_dp_y", dp_Y_in, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            run_walk($sformatf("vec%0d", i), '{x: vecs[i].sx, y: vecs[i].sy}, vecs[i].nsteps,
                     vecs[i].stall_at, vecs[i].stall_len, 1'b0, vecs[i].poke, -1);
            check($sformatf("vec%0d n", i), got.size(), vecs[i].exp_n);
            if (vecs[i].exp_n > 0 && got.size() > 0) begin
                check($sformatf("vec%0d last_x", i), got[got.size()-1].x, vecs[i].exp_lx);
                check($sformatf("vec%0d last_y", i), got[got.size()-1].y, vecs[i].exp_ly);
            end
        end

        // Reset applied between edges while a point is waiting in EMIT.
        @(posedge clk); #1;
        seed_X = 5; seed_Y = 1; steps = 3; start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("midrst pre_valid", out_valid, 1);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        check("midrst valid", out_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst out_x", out_X, 0);
        check("midrst dp_x", dp_X_in, 0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst no_valid", out_valid, 0);
        end
        run_walk("postrst", '{x: 16, y: 13}, 1, -1, 0, 1'b0, 1'b0, -1);
        if (got.size() > 0) begin
            check("postrst x", got[0].x, 0);
            check("postrst y", got[0].y, 6);
        end

`ifdef EC_WALK_ABORT_EN
        run_walk("abort", G, 10, -1, 0, 1'b0, 1'b0, 2);
`endif

        for (int w = 0; w < 30; w++) begin
            rp = G;
            for (int j = $urandom_range(0, 7); j > 0; j--) rp = ec_add(rp, G);
            run_walk("rnd", rp, $urandom_range(0, 7), -1, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ec_walk_ctrl.md
EC_WALK_CTRL -- requirements
Module: ec_walk_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of each point coordinate.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the step count.
REQ-003 SHALL have parameter DP_LATENCY, default 2, point-add datapath latency in cycles, legal range 1..15.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports seed_X, seed_Y  in  DATA_WIDTH  start point of the walk.
REQ-007 SHALL have port steps  in  CNT_WIDTH  number of points to emit.
REQ-008 SHALL have port start  in  1  single-cycle request to begin a walk.
REQ-009 SHALL have ports dp_X_in, dp_Y_in  out  DATA_WIDTH  registered operand to the point-add datapath.
REQ-010 SHALL have ports dp_X_out, dp_Y_out  in  DATA_WIDTH  datapath result (operand + G).
REQ-011 SHALL have ports out_X, out_Y  out  DATA_WIDTH  emitted point; out_valid out 1; out_ready in 1.
REQ-012 SHALL have ports busy  out  1  (state != IDLE) and done  out  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, WAIT, EMIT, DONE.
REQ-014 IDLE: on start=1 with steps!=0, SHALL latch steps into remaining, register seed into dp_X_in/dp_Y_in, clear wait counter, go WAIT.
REQ-015 IDLE: on start=1 with steps=0, SHALL go DONE without driving the datapath or asserting out_valid.
REQ-016 WAIT: SHALL hold dp_X_in/dp_Y_in stable and increment wait counter each cycle; on the edge where counter = DP_LATENCY-1 SHALL capture dp_X_out/dp_Y_out into out_X/out_Y, set out_valid, go EMIT.
REQ-017 out_valid SHALL therefore rise exactly DP_LATENCY cycles after the accepting start edge or the prior handshake edge.
REQ-018 EMIT: out_X, out_Y, out_valid SHALL hold stable while out_ready=0 (no loss, no duplication).
REQ-019 EMIT with out_ready=1: SHALL clear out_valid, decrement remaining; if remaining was 1 go DONE, else register out_X/out_Y into dp_X_in/dp_Y_in, clear wait counter, go WAIT.
REQ-020 DONE: SHALL assert done for exactly one cycle, return to IDLE; done and out_valid SHALL never be high together.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 Walk state SHALL not depend on coordinate values; no modular arithmetic in this block.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, out_valid=0, done=0, busy=0, remaining=0, wait counter=0, out_X=out_Y=0, dp_X_in=dp_Y_in=0, independent of clk.
REQ-024 Reset asserted mid-walk SHALL discard the walk; after release no out_valid until a new start.

Configuration
REQ-025 Macro EC_WALK_ABORT_EN SHALL, when defined, add input abort (1 bit); abort=1 in WAIT or EMIT SHALL clear out_valid and go DONE on that edge (done pulses once), abort in IDLE/DONE ignored.
REQ-026 Without EC_WALK_ABORT_EN the abort port SHALL not exist and walks always run to completion.

Verification (behavioural datapath: y^2=x^3+2x+2 mod 17, adds G=(5,1), latency DP_LATENCY=2)
REQ-027 seed (5,1), steps=4, out_ready=1 -> outputs (6,3),(10,6),(3,1),(9,16), out_valid 2 cycles after each start/handshake, one done pulse, busy low after.
REQ-028 seed (5,1), steps=3, out_ready low 5 cycles at second point -> (10,6) held stable 5 cycles, sequence (6,3),(10,6),(3,1) unchanged.
REQ-029 steps=0 start -> done one cycle later, out_valid never asserted, dp_X_in unchanged.
REQ-030 start pulsed during WAIT of seed (5,1), steps=2 walk -> ignored; exactly (6,3),(10,6) emitted.
REQ-031 reset asserted between clock edges in EMIT -> out_valid, busy drop without waiting for an edge; next start with seed (16,13), steps=1 -> (0,6).
REQ-032 With EC_WALK_ABORT_EN: seed (5,1), steps=10, abort in EMIT of third point -> outputs (6,3),(10,6) only, done pulses once, state IDLE.
